// File: rtl/config_writer_pkg.sv
// Shared types and widths for the configuration frame writer.
// Holds the FSM state encoding, address field width and counter width.
package config_writer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   localparam int AddrW = 8;
   localparam int CntW  = 16;

endpackage

// File: rtl/config_frame_writer_strobe_decoder.sv
// Registered index-to-one-hot latch-enable decoder.
// Output is all-zero unless enabled; out-of-range indices decode to zero.
module strobe_decoder
   import config_writer_pkg::*;
#(
   parameter int Width = 20
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic [AddrW-1:0] index,
   output logic [Width-1:0] strobe
);

   logic [Width-1:0] onehot;

   // decode the index into a single set bit
   always_comb begin
      onehot = '0;
      for (int i = 0; i < Width; i++) begin
         onehot[i] = (32'(index) == i);
      end
   end

   // register the strobe so the latch enables never glitch
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         strobe <= '0;
      end else if (en) begin
         strobe <= onehot;
      end else begin
         strobe <= '0;
      end
   end

endmodule

// File: rtl/config_frame_writer.sv
// Address/data word pair to frame latch writer: SETUP, STROBE, HOLD timing.
// Optional FRAME_COUNT_EN builds a saturating frames_written counter.
module config_frame_writer
   import config_writer_pkg::*;
#(
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20,
   parameter int StrobeCycles    = 1
) (
   input  logic                       CLK,
   input  logic                       resetn,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [FrameBitsPerRow-1:0] s_data,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       addr_err,
   output logic [CntW-1:0]            frames_written
);

   state_t           state;
   state_t           state_nx;
   logic [AddrW-1:0] idx_q;
   logic [3:0]       cyc_q;
   logic             legal;
   logic             cyc_last;
   logic             strobe_en;

   assign legal    = (32'(idx_q) < MaxFramesPerCol);
   assign cyc_last = (cyc_q == 4'(StrobeCycles - 1));

   // state register
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state decode; missing s_valid simply parks in IDLE or DATA
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (s_valid) state_nx = DATA;
         DATA:    if (s_valid) state_nx = legal ? SETUP : IDLE;
         SETUP:   state_nx = STROBE;
         STROBE:  if (cyc_last) state_nx = HOLD;
         HOLD:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // handshake and status outputs
   always_comb begin
      s_ready   = (state == IDLE) || (state == DATA);
      busy      = (state != IDLE);
      strobe_en = (state_nx == STROBE);
   end

   // capture frame index on the address word
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         idx_q <= '0;
      end else if (state == IDLE && s_valid) begin
         idx_q <= s_data[AddrW-1:0];
      end
   end

   // FrameData moves only on a data-word accept, even for a bad index
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         FrameData <= '0;
      end else if (state == DATA && s_valid) begin
         FrameData <= s_data;
      end
   end

   // sticky out-of-range flag, cleared only by reset
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         addr_err <= 1'b0;
      end else if (state == DATA && s_valid && !legal) begin
         addr_err <= 1'b1;
      end
   end

   // counts cycles spent in STROBE
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         cyc_q <= '0;
      end else if (state == STROBE) begin
         cyc_q <= cyc_q + 4'd1;
      end else begin
         cyc_q <= '0;
      end
   end

   strobe_decoder #(
      .Width (MaxFramesPerCol)
   ) u_dec (
      .clk    (CLK),
      .resetn (resetn),
      .en     (strobe_en),
      .index  (idx_q),
      .strobe (FrameStrobe)
   );

`ifdef FRAME_COUNT_EN
   logic [CntW-1:0] cnt_q;

   // saturating count of completed strobes
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (state == STROBE && cyc_last && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign frames_written = cnt_q;
`else
   assign frames_written = '0;
`endif

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer (default and StrobeCycles=3).
// Expected strobe/data pairs are queued on write and popped at pulse start.
module tb_config_frame_writer;

   localparam int W = 32;
   localparam int N = 20;

   typedef struct {
      logic [N-1:0] strobe;
      logic [W-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic [W-1:0]  frame_data;
   logic [N-1:0]  frame_strobe;
   logic          busy;
   logic          addr_err;
   logic [15:0]   frames_written;

   logic          v3;
   logic          rdy3;
   logic [W-1:0]  d3;
   logic [W-1:0]  fd3;
   logic [N-1:0]  strobe3;
   logic          busy3;
   logic          err3;
   logic [15:0]   fw3;

   exp_t sb[$];
   exp_t e;
   int   run = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   config_frame_writer dut (
      .CLK            (clk),
      .resetn         (resetn),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .FrameData      (frame_data),
      .FrameStrobe    (frame_strobe),
      .busy           (busy),
      .addr_err       (addr_err),
      .frames_written (frames_written)
   );

   config_frame_writer #(.StrobeCycles(3)) dut3 (
      .CLK            (clk),
      .resetn         (resetn),
      .s_valid        (v3),
      .s_ready        (rdy3),
      .s_data         (d3),
      .FrameData      (fd3),
      .FrameStrobe    (strobe3),
      .busy           (busy3),
      .addr_err       (err3),
      .frames_written (fw3)
   );

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(logic [W-1:0] w);
      int n = 0;
      s_valid = 1'b1;
      s_data  = w;
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("send_timeout", 64'(s_ready), 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic gap(int maxg);
      repeat ($urandom_range(0, maxg)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_frame(int idx, logic [W-1:0] d, bit push, int maxg);
      exp_t x;
      if (push) begin
         x.strobe = '0;
         x.strobe[idx] = 1'b1;
         x.data = d;
         sb.push_back(x);
      end
      send(W'(idx));
      gap(maxg);
      send(d);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 64'(busy), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 resetn = 1'b0;
      @(negedge clk);
      check("rst_data", frame_data, 0);
      check("rst_strobe", frame_strobe, 0);
      check("rst_err", 64'(addr_err), 0);
      check("rst_fw", frames_written, 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_ready", 64'(s_ready), 1);
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // scoreboard monitor and per-cycle invariants
   always @(negedge clk) begin
      check("onehot", 64'($onehot0(frame_strobe)), 1);
`ifndef FRAME_COUNT_EN
      check("fw_zero", frames_written, 0);
`endif
      if (!resetn) begin
         run = 0;
      end else if (frame_strobe != '0) begin
         if (run == 0) begin
            if (sb.size() == 0) begin
               check("strobe_unexp", frame_strobe, 0);
            end else begin
               e = sb.pop_front();
               check("sb_strobe", frame_strobe, e.strobe);
               check("sb_data", frame_data, e.data);
            end
         end
         run++;
      end else if (run != 0) begin
         check("strobe_len", run, 1);
         run = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lo;
      int hi;
      s_valid = 1'b0;
      s_data  = '0;
      v3 = 1'b0;
      d3 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_data", frame_data, 0);
      check("rst_strobe", frame_strobe, 0);
      check("rst_err", 64'(addr_err), 0);
      check("rst_fw", frames_written, 0);
      check("rst_busy", 64'(busy), 0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // StrobeCycles=3 instance, address 0
      v3 = 1'b1;
      d3 = '0;
      @(posedge clk);
      #1 d3 = 32'h12345678;
      @(posedge clk);
      #1 v3 = 1'b0;
      lo = 0;
      hi = 0;
      repeat (8) begin
         @(negedge clk);
         if (!rdy3) lo++;
         if (strobe3 == 20'h1) hi++;
      end
      check("sc3_strobe_cycles", hi, 3);
      check("sc3_ready_low", lo, 5);
      check("sc3_data", fd3, 32'h12345678);
      @(posedge clk);
      #1;

      // addr 3, data DEADBEEF back-to-back
      write_frame(3, 32'hDEADBEEF, 1, 0);
      @(negedge clk);
      check("setup_strobe", frame_strobe, 0);
      check("setup_data", frame_data, 32'hDEADBEEF);
      check("setup_ready", 64'(s_ready), 0);
      @(negedge clk);
      check("strobe_val", frame_strobe, 20'h00008);
      check("strobe_data", frame_data, 32'hDEADBEEF);
      @(negedge clk);
      check("hold_strobe", frame_strobe, 0);
      check("hold_data", frame_data, 32'hDEADBEEF);
      check("hold_busy", 64'(busy), 1);
      @(negedge clk);
      check("idle_ready", 64'(s_ready), 1);
      check("idle_busy", 64'(busy), 0);
      @(posedge clk);
      #1;

      // out-of-range index 20
      write_frame(20, 32'h1, 0, 0);
      @(negedge clk);
      check("oor_err", 64'(addr_err), 1);
      check("oor_ready", 64'(s_ready), 1);
      check("oor_data", frame_data, 32'h1);
      repeat (4) begin
         @(negedge clk);
         check("oor_strobe", frame_strobe, 0);
      end
      check("oor_err_sticky", 64'(addr_err), 1);
      @(posedge clk);
      #1;

      // reset in the middle of STROBE
      write_frame(7, 32'h0BADF00D, 0, 0);
      @(posedge clk);
      #1 check("mid_strobe_on", frame_strobe, 20'h00080);
      #1 resetn = 1'b0;
      #1 check("mid_strobe_off", frame_strobe, 0);
      check("mid_data_clr", frame_data, 0);
      check("mid_busy", 64'(busy), 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("mid_err_clr", 64'(addr_err), 0);
      @(posedge clk);
      #1;
      write_frame(5, 32'hA5A5A5A5, 1, 0);
      wait_idle();
      check("post_rst_data", frame_data, 32'hA5A5A5A5);

      // frames 0..19 with random gaps
      pulse_reset();
      for (int i = 0; i < N; i++) begin
         gap(3);
         write_frame(i, $urandom, 1, 3);
      end
      wait_idle();
`ifdef FRAME_COUNT_EN
      check("fw_count", frames_written, 20);
`else
      check("fw_count", frames_written, 0);
`endif
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, width of FrameData and of the input word.
REQ-002 SHALL have parameter MaxFramesPerCol, default 20, number of FrameStrobe lines; legal frame indices are 0..MaxFramesPerCol-1.
REQ-003 SHALL have parameter StrobeCycles, default 1, range 1..15, number of cycles FrameStrobe is held high per write.
REQ-004 SHALL be clocked by a single clock and reset asynchronously, active-low, with no other clock or reset.
REQ-005 SHALL have port CLK, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port s_valid, input, 1 bit, input word valid.
REQ-008 SHALL have port s_ready, output, 1 bit, input word accepted when s_valid and s_ready are both high.
REQ-009 SHALL have port s_data, input, FrameBitsPerRow bits, address or data word.
REQ-010 SHALL have port FrameData, output, FrameBitsPerRow bits, frame data to the column latches.
REQ-011 SHALL have port FrameStrobe, output, MaxFramesPerCol bits, one-hot latch enable.
REQ-012 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-013 SHALL have port addr_err, output, 1 bit, sticky flag for an out-of-range frame index.
REQ-014 SHALL have port frames_written, output, 16 bits, count of frames written.

Function
REQ-015 SHALL implement FSM states IDLE, DATA, SETUP, STROBE, HOLD.
REQ-016 In IDLE, s_ready SHALL be 1; an accepted word is the address; frame index = s_data[7:0]; next state DATA.
REQ-017 In DATA, s_ready SHALL be 1; the accepted word SHALL load FrameData; next state SETUP if the index is legal, otherwise IDLE with addr_err set and no strobe.
REQ-018 In SETUP, STROBE and HOLD, s_ready SHALL be 0.
REQ-019 SETUP SHALL last exactly 1 cycle, with FrameData stable and FrameStrobe all zero.
REQ-020 STROBE SHALL last exactly StrobeCycles cycles, with FrameStrobe[index]=1, all other strobe bits 0, and FrameData unchanged.
REQ-021 HOLD SHALL last exactly 1 cycle, with FrameStrobe zero and FrameData unchanged; next state IDLE.
REQ-022 Minimum spacing SHALL be 2+1+StrobeCycles+1 cycles per frame (5 for the default StrobeCycles).
REQ-023 FrameData SHALL change only on a DATA-state accept.
REQ-024 FrameStrobe SHALL never have more than one bit set, and SHALL be registered (glitch-free).
REQ-025 addr_err SHALL clear only on reset.
REQ-026 Gaps in s_valid SHALL cause the FSM to stay in IDLE or DATA indefinitely with no side effects.

Reset
REQ-027 While resetn=0, the block SHALL be in IDLE with FrameData=0, FrameStrobe=0, addr_err=0, frames_written=0 and busy=0.
REQ-028 Reset asserted during STROBE SHALL drop FrameStrobe to 0 asynchronously; the partial write is abandoned.
REQ-029 After reset release, the first accepted word SHALL be treated as an address.

Configuration
REQ-030 With macro FRAME_COUNT_EN defined, frames_written SHALL increment by 1 on each STROBE-to-HOLD transition, saturating at 16'hFFFF.
REQ-031 Without FRAME_COUNT_EN, frames_written SHALL be constant 0 and no counter logic SHALL be generated.

Structure
REQ-032 A shared package config_writer_pkg SHALL hold the FSM state enum, the address field width (8), and the counter width (16).
REQ-033 The block SHALL have one sub-module, strobe_decoder: registered index-to-one-hot conversion with enable, width MaxFramesPerCol.

Verification
REQ-034 The bench SHALL apply reset then addr 3, data 32'hDEADBEEF back-to-back, and check FrameStrobe=20'h00008 for 1 cycle, 1 cycle after the data accept, with FrameData=DEADBEEF from SETUP through HOLD.
REQ-035 The bench SHALL write frame index 20, then data 32'h1, and check addr_err=1, FrameStrobe stays 0, FrameData=1, and s_ready returns to 1 after 1 cycle.
REQ-036 The bench SHALL run with StrobeCycles=3 and addr 0 and check FrameStrobe[0] high for exactly 3 cycles and s_ready low for 5 cycles.
REQ-037 The bench SHALL assert resetn=0 mid-STROBE and check FrameStrobe=0 with no clock edge, then after release send addr 5, data 32'hA5A5A5A5 and check a normal write.
REQ-038 The bench SHALL, with FRAME_COUNT_EN defined, write frames 0..19 with random s_valid gaps and check frames_written=20, strobes in order, and one-hot at every cycle.
REQ-039 The bench SHALL, without FRAME_COUNT_EN, repeat the REQ-038 frame 0..19 sequence and check frames_written=0 throughout.
